// File: rtl/sparse_index_scheduler.sv
// sparse_index_scheduler: latches an n-bit occupancy mask and emits the index of
// every set bit, lowest index first, one per valid/ready handshake. A zero
// mask produces only a done pulse. abort flushes the current mask silently.
// Optional build macro SPARSE_SCHED_COUNT_EN adds emitted_cnt, the number of
// indices transferred since the last load accept.
module sparse_index_scheduler #(
  parameter int n    = 8,
  parameter int logn = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load_valid,
  input  logic [n-1:0]    load_mask,
  output logic            load_ready,
  output logic            idx_valid,
  output logic [logn-1:0] idx_addr,
  output logic            idx_last,
  input  logic            idx_ready,
  input  logic            abort,
`ifdef SPARSE_SCHED_COUNT_EN
  output logic [logn:0]   emitted_cnt,
`endif
  output logic            done
);

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

  localparam logic [n-1:0] one_n = {{(n-1){1'b0}}, 1'b1};

  state_t          state_reg;
  logic [n-1:0]    pend_reg;
  logic            done_reg;
  logic [n-1:0]    low_onehot;
  logic [logn-1:0] enc_addr;
  logic            single_bit;
  logic            run;

  // Isolate the lowest pending bit; bit 0 has the highest priority.
  assign low_onehot = pend_reg & (~pend_reg + one_n);
  // Exactly one bit pending when clearing the lowest bit leaves nothing.
  assign single_bit = ((pend_reg & (pend_reg - one_n)) == '0);
  assign run        = (state_reg == RUN);

  // Binary-encode the isolated lowest bit: address bit gi is the OR of every
  // one-hot position whose index has bit gi set.
  genvar gi, gj;
  generate
    for (gi = 0; gi < logn; gi++) begin : g_enc
      logic [n-1:0] sel;
      for (gj = 0; gj < n; gj++) begin : g_sel
        assign sel[gj] = low_onehot[gj] & (((gj >> gi) % 2) == 1);
      end
      assign enc_addr[gi] = |sel;
    end
  endgenerate

  // Index outputs are decoded from registers only and forced to zero outside RUN.
  assign idx_valid  = run;
  assign idx_addr   = run ? enc_addr : '0;
  assign idx_last   = run & single_bit;
  assign load_ready = (state_reg == IDLE);
  assign done       = done_reg;

  // Main FSM: load in IDLE, drain one index per handshake in RUN, abort flushes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      pend_reg  <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (abort) begin
        // A coincident transfer is considered delivered; the remainder is dropped.
        state_reg <= IDLE;
        pend_reg  <= '0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (load_valid) begin
              pend_reg <= load_mask;
              if (load_mask == '0) begin
                done_reg <= 1'b1;
              end else begin
                state_reg <= RUN;
              end
            end
          end
          RUN: begin
            if (idx_ready) begin
              pend_reg <= pend_reg & ~low_onehot;
              if (single_bit) begin
                state_reg <= IDLE;
                done_reg  <= 1'b1;
              end
            end
          end
          default: begin
            state_reg <= IDLE;
            pend_reg  <= '0;
          end
        endcase
      end
    end
  end

`ifdef SPARSE_SCHED_COUNT_EN
  localparam logic [logn:0] one_c = {{logn{1'b0}}, 1'b1};
  logic [logn:0] cnt_reg;

  // Count transfers since the last load; the value survives done until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (abort) begin
      cnt_reg <= '0;
    end else if (load_ready && load_valid) begin
      cnt_reg <= '0;
    end else if (run && idx_ready) begin
      cnt_reg <= cnt_reg + one_c;
    end
  end

  assign emitted_cnt = cnt_reg;
`endif

endmodule

// File: doc/sparse_index_scheduler.md
Name: sparse_index_scheduler

Overview:
- Sequences the lowest-set-bit priority encoder across a whole occupancy mask.
- Latches an n-bit sparsity mask and emits the index of every set bit, lowest index first, one per valid/ready handshake.
- Sits between the mask source, for example a row/column nonzero bitmap, and the sparse MAC datapath that fetches operands by index.

Parameters:
- n, 8, mask width in bits; power of two, at least 2.
- logn, 3, index width; must equal log2(n).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load_valid  in  1  mask offered.
- load_mask  in  n  mask to schedule; bit 0 has the highest priority.
- load_ready  out  1  block can accept a mask.
- idx_valid  out  1  idx_addr holds a pending index.
- idx_addr  out  logn  lowest pending set-bit index.
- idx_last  out  1  idx_addr is the final pending index of this mask.
- idx_ready  in  1  downstream consumes idx_addr.
- abort  in  1  synchronous flush of the current mask.
- done  out  1  one-cycle pulse after the final index is consumed, or after a zero mask is accepted.

Behaviour:
- State register: IDLE or RUN. Pending register pend[n-1:0].
- Reset (rst_n low, asynchronous) values:
  - state=IDLE, pend=0, done=0.
  - idx_valid=0, idx_addr=0, idx_last=0, load_ready=1.
- load_ready = (state==IDLE). It is decoded from registered state only, with no combinational path from inputs.
- IDLE:
  - Load is accepted when load_valid & load_ready; pend <= load_mask.
  - If load_mask != 0: next state is RUN.
  - If load_mask == 0: stay in IDLE and assert done in the next cycle. No index is emitted.
- RUN outputs:
  - idx_valid = 1.
  - idx_addr = index of the lowest 1 in pend.
  - idx_last = (pend has exactly one bit set).
  - All three are combinational from registers.
- RUN transfer:
  - A transfer occurs when idx_valid & idx_ready; that cycle, pend <= pend with bit idx_addr cleared.
  - If the transfer had idx_last=1: next state is IDLE and done=1 in the following cycle.
- RUN backpressure: idx_ready=0 holds pend, idx_addr and idx_last stable. idx_valid never drops without a transfer or abort.
- Timing:
  - Latency is load accept at cycle t -> first idx_valid at t+1.
  - Throughput is 1 index/cycle while idx_ready=1.
- Outside RUN: idx_valid=0, idx_addr=0, idx_last=0 (gated).
- done:
  - Registered; high exactly one cycle.
  - load_ready is 1 in the done cycle, so a new load may be accepted then.
- abort:
  - In any state: pend <= 0, state <= IDLE, no done pulse.
  - If abort coincides with a transfer, the transfer counts as delivered. The rest of the mask is discarded.
  - If abort coincides with a load accept in IDLE, abort wins and the mask is dropped.
- load_valid during RUN is ignored (load_ready=0); the mask is not latched.
- Index arithmetic is unsigned, logn bits. Bit n-1 yields index n-1; there is no wrap.

Optional Feature:
- Macro: SPARSE_SCHED_COUNT_EN.
- Defined:
  - Adds output emitted_cnt, width logn+1.
  - Cleared to 0 on reset, on load accept, and on abort.
  - Increments by 1 on each index transfer.
  - Holds its value after done until the next load, so n=8 with 8'hFF reports 8.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Load 8'b00011010, idx_ready=1 -> idx_addr 1,3,4 on three consecutive cycles; idx_last only with 4; done high the next cycle; load_ready back to 1.
- Load 8'b10000001, hold idx_ready=0 for 3 cycles -> idx_valid=1 and idx_addr=0 stable throughout. Release -> idx_addr 0 then 7 (last), then done.
- Load 8'h00 -> idx_valid never asserts; done pulses exactly one cycle after accept; count=0 if SPARSE_SCHED_COUNT_EN.
- Load 8'hFF, idx_ready=1 -> idx_addr 0..7 over 8 cycles, idx_last on 7. Drive load_valid with 8'h0F mid-run -> ignored, no extra indices. Count=8 if enabled.
- Load 8'b01011000, abort asserted in the cycle index 3 transfers -> next cycle idx_valid=0, load_ready=1, no done pulse. A fresh 8'h02 load then yields idx_addr 1.
- Load 8'hF0, assert rst_n=0 asynchronously after the first transfer -> outputs immediately take reset values. After release, no stale indices appear and load_ready=1.
